board_debug_ctrl: RTL and testbench
===================================

# board_debug_ctrl

Parametrised board-level run/step and debug-display controller for the DE1 CPU top level. It replaces the fixed clock divider and hard-wired HEX/LED mapping with:
- a clock-enable generator offering free-run and single-step modes;
- a button-selectable register viewer over the full register file;
- registered seven-segment and LED outputs.

It sits between the board pins and the FSM/datapath pair. The CPU runs on `clk`, gated by `cpu_ce`.

## Interface
- `CLK_DIV`, default 5_000_000 — `clk` cycles per `cpu_ce` pulse in RUN; must be ≥ 2.
- `NUM_REGS`, default 16 — registers in `reg_flat`; 2..16.
- `DATA_W`, default 16 — register width; 1..16, zero-extended to 16 for display.
- `DEBOUNCE_CYC`, default 250_000 — stable cycles required to accept a button level; must be ≥ 1.

Ports:
- `clk`  in  1  — system clock (50 MHz).
- `reset`  in  1  — synchronous, active-high.
- `btn_n`  in  3  — raw active-low keys, asynchronous to `clk`:
  - [0] step
  - [1] mode
  - [2] next
- `reg_flat`  in  NUM_REGS*DATA_W  — register r_i occupies bits [i*DATA_W +: DATA_W].
- `pc_count`  in  16  — CPU program counter.
- `flags`  in  5  — CPU flags.
- `cpu_ce`  out  1  — one-cycle clock enable to FSM/datapath.
- `run_mode`  out  1  — 1 = RUN, 0 = HALT.
- `sel`  out  4  — currently displayed register index.
- `hex0`..`hex5`  out  7 each  — active-low segments {g,f,e,d,c,b,a}.
- `ledr`  out  10  — {run_mode, sel[3:0], flags[4:0]}.

## Operation
**Button path.** For each `btn_n` bit:
- 2-flop synchroniser.
- Debouncer (see Configuration).
- Press detector: a 1-cycle pulse on the debounced 1→0 transition.
- Holding a key produces exactly one pulse.

**Mode FSM.** States RUN and HALT.
- A mode pulse toggles the state.
- RUN: a divider counts 0..CLK_DIV-1. `cpu_ce`=1 in the cycle the count equals CLK_DIV-1, then the count wraps to 0.
- HALT: the divider is held at 0. Each step pulse yields exactly one `cpu_ce` cycle.
- Step pulses in RUN are ignored.
- Mode and step pulses in the same cycle: the mode change wins and the step is dropped.
- Entering RUN clears the divider, so the first `cpu_ce` occurs CLK_DIV cycles after the transition.

**Selector.**
- A next pulse increments `sel`.
- `sel` wraps from NUM_REGS-1 to 0.
- `sel` is independent of mode.

**Display.** All display outputs are registered from the current inputs.
- hex3..hex0: the 16-bit zero-extended value of r[sel], digit 0 on hex0.
- hex5..hex4: `pc_count[7:0]`.
- Encoding for digits 0–F, active-low hex values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

**Reset.**
- Mode = RUN, `sel` = 0, divider = 0, debouncers hold the released state.
- `cpu_ce` = 0, all hex outputs = 7F (blank), `ledr` = 0.
- Reset asserted mid-operation takes effect on the next edge and aborts any pending step pulse.

## Timing
- Button latency, from the raw edge to the pulse: 2 synchroniser cycles + DEBOUNCE_CYC + 1 cycle.
- Step pulse → `cpu_ce`: 1 cycle. `run_mode`/`sel` update in the same cycle as `cpu_ce` would.
- `reg_flat`, `pc_count` or `flags` change → hex/`ledr` update: 1 cycle.
- `sel` change → hex3..0 show the new register 1 cycle later.
- `cpu_ce` never high for two consecutive cycles (guaranteed because CLK_DIV ≥ 2).
- `cpu_ce` never high while `reset` is high.

## Configuration
- `BOARD_DBG_DEBOUNCE_EN` defined: a per-button counter must observe DEBOUNCE_CYC consecutive identical synchronised samples before the debounced level changes. A bounce restarts the count.
- Not defined: the debounced level equals the synchroniser output and DEBOUNCE_CYC is unused. This is intended for fast simulation; latency becomes 3 cycles.

## Test plan
Use CLK_DIV=4, DEBOUNCE_CYC=3, NUM_REGS=16, DATA_W=16 for all scenarios.
- **Reset:** hold `reset` 2 cycles → `cpu_ce`=0, `run_mode`=1, `sel`=0, hex0..5=7F, `ledr`=0. After release, `cpu_ce` pulses at cycles 4, 8, 12.
- **Mode/step:** mode press → `run_mode`=0 and no `cpu_ce`. Three step presses → exactly three single-cycle `cpu_ce` pulses. Step held for 20 cycles → one pulse. Step pulse while `run_mode`=1 → no extra `cpu_ce`.
- **Selector:** r3=16'hA5F0 in `reg_flat`, three next presses → `sel`=3, hex3..hex0 = 08,12,0E,40. Press next 13 more times → `sel`=0 (wrap).
- **Debounce:** with the macro, a 2-cycle low glitch on `btn_n[2]` → no `sel` change; a 3-cycle-stable low → `sel` increments once. Without the macro, the same glitch increments `sel`.
- **Collision/reset:** mode and step pulses coincide in HALT → RUN, no immediate `cpu_ce`. `reset` asserted one cycle after a step press in HALT → no `cpu_ce`, state = RUN, `sel` = 0.
- **Display:** `pc_count`=16'h001B, `flags`=5'b10101 → hex5=79, hex4=03, `ledr`[4:0]=10101, one cycle after the inputs change.

Source files
------------

// File: rtl/board_debug_ctrl.sv
// board_debug_ctrl: run/step clock-enable generator, button-driven register viewer and HEX/LED display.
// Optional feature: define BOARD_DBG_DEBOUNCE_EN for counter-based button debouncing.
module board_debug_ctrl #(
  parameter int CLK_DIV      = 5_000_000,
  parameter int NUM_REGS     = 16,
  parameter int DATA_W       = 16,
  parameter int DEBOUNCE_CYC = 250_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 btn_n,
  input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
  input  logic [15:0]                pc_count,
  input  logic [4:0]                 flags,
  output logic                       cpu_ce,
  output logic                       run_mode,
  output logic [3:0]                 sel,
  output logic [6:0]                 hex0,
  output logic [6:0]                 hex1,
  output logic [6:0]                 hex2,
  output logic [6:0]                 hex3,
  output logic [6:0]                 hex4,
  output logic [6:0]                 hex5,
  output logic [9:0]                 ledr
);
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic {S_HALT = 1'b0, S_RUN = 1'b1} state_t;

  if (CLK_DIV < 2 || NUM_REGS < 2 || NUM_REGS > 16 || DATA_W < 1 || DATA_W > 16 ||
      DEBOUNCE_CYC < 1) begin : g_param_check
    $error("board_debug_ctrl: parameter out of range");
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [2:0] r_sync1, r_sync2, r_deb_prev, r_press;
  logic [2:0] w_deb;

  // Stage: two-flop synchroniser, released level on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BOARD_DBG_DEBOUNCE_EN
  localparam int DBC_W = $clog2(DEBOUNCE_CYC + 1);
  logic [2:0]       r_deb;
  logic [DBC_W-1:0] r_dbc [3];

  // Stage: debounce, level flips only after DEBOUNCE_CYC consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb <= 3'b111;
      for (int b = 0; b < 3; b++) r_dbc[b] <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (r_sync2[b] == r_deb[b]) begin
          r_dbc[b] <= '0;
        end else if (r_dbc[b] == DBC_W'(DEBOUNCE_CYC - 1)) begin
          r_deb[b] <= r_sync2[b];
          r_dbc[b] <= '0;
        end else begin
          r_dbc[b] <= r_dbc[b] + 1'b1;
        end
      end
    end
  end
  assign w_deb = r_deb;
`else
  assign w_deb = r_sync2;
`endif

  // Stage: press detect, one pulse per debounced falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb_prev <= 3'b111;
      r_press    <= '0;
    end else begin
      r_deb_prev <= w_deb;
      r_press    <= r_deb_prev & ~w_deb;
    end
  end

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_ce, w_ce_nxt;
  logic [3:0]       r_sel, w_sel_nxt;

  // Stage: mode FSM, divider and selector
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_div   <= '0;
      r_ce    <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_ce    <= w_ce_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // A mode pulse swallows any coincident step pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_ce_nxt    = 1'b0;
    w_sel_nxt   = r_sel;
    if (r_press[1]) begin
      w_state_nxt = (r_state == S_RUN) ? S_HALT : S_RUN;
      w_div_nxt   = '0;
    end else if (r_state == S_RUN) begin
      if (r_div == DIV_W'(CLK_DIV - 1)) begin
        w_ce_nxt  = 1'b1;
        w_div_nxt = '0;
      end else begin
        w_div_nxt = r_div + 1'b1;
      end
    end else begin
      w_div_nxt = '0;
      w_ce_nxt  = r_press[0];
    end
    if (r_press[2]) begin
      w_sel_nxt = (r_sel == 4'(NUM_REGS - 1)) ? 4'd0 : r_sel + 1'b1;
    end
  end

  logic [15:0] w_reg_val;
  logic        w_unused_pc_hi;
  assign w_unused_pc_hi = ^pc_count[15:8];

  always_comb begin
    w_reg_val               = '0;
    w_reg_val[DATA_W-1:0]   = reg_flat[r_sel*DATA_W +: DATA_W];
  end

  logic [6:0] r_hex [6];
  logic [9:0] r_ledr;

  // Stage: registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 6; d++) r_hex[d] <= 7'h7F;
      r_ledr <= '0;
    end else begin
      for (int d = 0; d < 4; d++) r_hex[d] <= seg7(w_reg_val[4*d +: 4]);
      r_hex[4] <= seg7(pc_count[3:0]);
      r_hex[5] <= seg7(pc_count[7:4]);
      r_ledr   <= {run_mode, r_sel, flags};
    end
  end

  // Masking with reset keeps the enable low for the whole reset cycle.
  assign cpu_ce   = r_ce & ~reset;
  assign run_mode = (r_state == S_RUN);
  assign sel      = r_sel;
  assign hex0     = r_hex[0];
  assign hex1     = r_hex[1];
  assign hex2     = r_hex[2];
  assign hex3     = r_hex[3];
  assign hex4     = r_hex[4];
  assign hex5     = r_hex[5];
  assign ledr     = r_ledr;

endmodule

// File: tb/tb_board_debug_ctrl.sv
// Randomized and directed bench for board_debug_ctrl against a cycle-indexed behavioural model.
`timescale 1ns/1ps
module tb_board_debug_ctrl;
  localparam int CLK_DIV = 4, NUM_REGS = 16, DATA_W = 16, DEBOUNCE_CYC = 3;
`ifdef BOARD_DBG_DEBOUNCE_EN
  localparam int LAT    = DEBOUNCE_CYC + 3;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif
  localparam int SETTLE = LAT + DEBOUNCE_CYC + 6;
  localparam int MAXC   = 16384;

  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] btn_n = 3'b111;
  logic [NUM_REGS*DATA_W-1:0] reg_flat = '0;
  logic [15:0] pc_count = '0;
  logic [4:0] flags = '0;
  logic cpu_ce, run_mode;
  logic [3:0] sel;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [9:0] ledr;
  logic [6:0] dut_hex [6];

  always #5 clk = ~clk;

  board_debug_ctrl #(.CLK_DIV(CLK_DIV), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W),
                     .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .reg_flat(reg_flat), .pc_count(pc_count),
    .flags(flags), .cpu_ce(cpu_ce), .run_mode(run_mode), .sel(sel),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .ledr(ledr));

  assign dut_hex[0] = hex0; assign dut_hex[1] = hex1; assign dut_hex[2] = hex2;
  assign dut_hex[3] = hex3; assign dut_hex[4] = hex4; assign dut_hex[5] = hex5;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: per-edge histories of synchronised level, debounced level and press pulses.
  logic [2:0] m_s [MAXC];
  logic [2:0] m_raw [MAXC];
  logic [2:0] m_deb [MAXC];
  logic [2:0] m_prs [MAXC];
  int m_e = 0, m_sel = 0, m_run_start = 0;
  bit m_run = 1'b1, m_ce = 1'b0, m_valid = 1'b0;
  logic [6:0] m_hex [6];
  logic [9:0] m_ledr = '0;

  initial begin
    m_raw[0] = 3'b111; m_s[0] = 3'b111; m_deb[0] = 3'b111; m_prs[0] = 3'b000;
  end

  always @(posedge clk) begin
    logic [2:0] p;
    logic [15:0] v;
    bit flip;
    m_e++;
    if (m_e >= MAXC) begin
      $display("FAIL model_capacity: got %0d cycles, expected below %0d", m_e, MAXC);
      $fatal(1, "model history exhausted");
    end
    if (reset) begin
      m_raw[m_e] = 3'b111; m_s[m_e] = 3'b111; m_deb[m_e] = 3'b111; m_prs[m_e] = 3'b000;
      m_run = 1'b1; m_sel = 0; m_ce = 1'b0; m_run_start = m_e; m_ledr = '0;
      for (int d = 0; d < 6; d++) m_hex[d] = 7'h7F;
    end else begin
      m_raw[m_e] = btn_n;
      m_s[m_e]   = m_raw[m_e-1];
      for (int b = 0; b < 3; b++) begin
        if (DEB_ON) begin
          flip = 1'b1;
          for (int k = 1; k <= DEBOUNCE_CYC; k++)
            if (m_e - k < 0 || m_s[m_e-k][b] == m_deb[m_e-1][b]) flip = 1'b0;
          m_deb[m_e][b] = flip ? ~m_deb[m_e-1][b] : m_deb[m_e-1][b];
        end else begin
          m_deb[m_e][b] = m_s[m_e][b];
        end
      end
      m_prs[m_e] = (m_e >= 2) ? (m_deb[m_e-2] & ~m_deb[m_e-1]) : 3'b000;
      v = reg_flat[m_sel*DATA_W +: DATA_W];
      for (int d = 0; d < 4; d++) m_hex[d] = SEG[(v >> (4*d)) & 16'hF];
      m_hex[4] = SEG[pc_count[3:0]];
      m_hex[5] = SEG[pc_count[7:4]];
      m_ledr = {m_run, 4'(m_sel), flags};
      p = m_prs[m_e-1];
      m_ce = 1'b0;
      if (p[1]) begin
        m_run = !m_run;
        m_run_start = m_e;
      end else if (m_run) begin
        m_ce = ((m_e - m_run_start) % CLK_DIV) == 0;
      end else begin
        m_ce = p[0];
      end
      if (p[2]) m_sel = (m_sel + 1) % NUM_REGS;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    #1;
    if (m_valid) begin
      chk("cpu_ce", 32'(cpu_ce), 32'(m_ce & ~reset));
      chk("run_mode", 32'(run_mode), 32'(m_run));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("ledr", 32'(ledr), 32'(m_ledr));
      for (int d = 0; d < 6; d++) chk($sformatf("hex%0d", d), 32'(dut_hex[d]), 32'(m_hex[d]));
    end
  end

  task automatic press(input int b, input int hold, output int nce);
    nce = 0;
    btn_n[b] = 1'b0;
    for (int i = 0; i < hold; i++) begin @(negedge clk); nce += int'(cpu_ce); end
    btn_n[b] = 1'b1;
    for (int i = 0; i < SETTLE; i++) begin @(negedge clk); nce += int'(cpu_ce); end
  endtask

  int rhold [3] = '{0, 0, 0};

  initial begin
    int n, tot;
    logic [13:0] got;

    // Reset held two cycles
    repeat (2) @(negedge clk);
    chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("rst_run_mode", 32'(run_mode), 32'd1);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_ledr", 32'(ledr), 32'd0);
    for (int d = 0; d < 6; d++) chk($sformatf("rst_hex%0d", d), 32'(dut_hex[d]), 32'h7F);
    reset = 1'b0;
    got = '0;
    for (int k = 1; k <= 13; k++) begin @(negedge clk); got[k] = cpu_ce; end
    chk("ce_after_reset", 32'(got), 32'h1110);

    // Mode to HALT, then step behaviour
    press(1, 4, n);
    chk("halt_run_mode", 32'(run_mode), 32'd0);
    tot = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); tot += int'(cpu_ce); end
    chk("halt_no_ce", 32'(tot), 32'd0);
    tot = 0;
    for (int i = 0; i < 3; i++) begin press(0, 4, n); tot += n; end
    chk("three_steps", 32'(tot), 32'd3);
    press(0, 20, n);
    chk("held_step", 32'(n), 32'd1);

    // Back to RUN; a step press must not add enables
    press(1, 4, n);
    chk("run_again", 32'(run_mode), 32'd1);
    tot = 0;
    btn_n[0] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      tot += int'(cpu_ce);
      if (i == 4) btn_n[0] = 1'b1;
    end
    chk("run_step_ignored", 32'(tot), 32'd10);
    repeat (SETTLE) @(negedge clk);

    // Selector
    for (int w = 0; w < NUM_REGS*DATA_W/32; w++) reg_flat[32*w +: 32] = $urandom;
    reg_flat[3*16 +: 16] = 16'hA5F0;
    for (int i = 0; i < 3; i++) press(2, 4, n);
    chk("sel_three", 32'(sel), 32'd3);
    chk("sel_hex3", 32'(hex3), 32'h08);
    chk("sel_hex2", 32'(hex2), 32'h12);
    chk("sel_hex1", 32'(hex1), 32'h0E);
    chk("sel_hex0", 32'(hex0), 32'h40);
    for (int i = 0; i < 13; i++) press(2, 4, n);
    chk("sel_wrap", 32'(sel), 32'd0);

    // Debounce glitch then a stable press
    press(2, 2, n);
    chk("glitch_sel", 32'(sel), DEB_ON ? 32'd0 : 32'd1);
    press(2, 3, n);
    chk("stable_sel", 32'(sel), DEB_ON ? 32'd1 : 32'd2);

    // Mode and step together while halted
    press(1, 4, n);
    chk("coll_halt", 32'(run_mode), 32'd0);
    tot = 0;
    btn_n[1:0] = 2'b00;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clk);
      tot += int'(cpu_ce);
      if (i == 4) btn_n[1:0] = 2'b11;
    end
    chk("coll_run_mode", 32'(run_mode), 32'd1);
    chk("coll_no_ce", 32'(tot), 32'd0);
    repeat (SETTLE) @(negedge clk);

    // Reset aborts a pending step
    press(2, 4, n);
    press(1, 4, n);
    tot = 0;
    btn_n[0] = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      tot += int'(cpu_ce);
      if (i == 3) btn_n[0] = 1'b1;
    end
    btn_n[0] = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin @(negedge clk); tot += int'(cpu_ce); end
    chk("abort_run_mode", 32'(run_mode), 32'd1);
    chk("abort_sel", 32'(sel), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); tot += int'(cpu_ce); end
    chk("abort_no_ce", 32'(tot), 32'd0);

    // Display path
    pc_count = 16'h001B;
    flags = 5'b10101;
    @(negedge clk);
    chk("disp_hex5", 32'(hex5), 32'h79);
    chk("disp_hex4", 32'(hex4), 32'h03);
    chk("disp_ledr", 32'(ledr[4:0]), 32'b10101);

    // Random traffic checked cycle by cycle against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int w = 0; w < NUM_REGS*DATA_W/32; w++) reg_flat[32*w +: 32] = $urandom;
      pc_count = 16'($urandom);
      flags = 5'($urandom);
      for (int b = 0; b < 3; b++) begin
        if (rhold[b] == 0) begin
          btn_n[b] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
          rhold[b] = $urandom_range(1, 8);
        end else begin
          rhold[b]--;
        end
      end
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
